// File: rtl/ctrl_pkg.sv
`default_nettype none
// ctrl_pkg: opcode/state types, mux select codes and instruction layout for ctrl_fsm.
// Rev 1.0
package ctrl_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_LDR  = 4'd1,
      OP_LDM  = 4'd2,
      OP_LDI  = 4'd3,
      OP_STR  = 4'd4,
      OP_JMP  = 4'd5,
      OP_HALT = 4'd6
   } opcode_e;

   typedef enum logic [2:0] {
      FETCH    = 3'd0,
      DECODE   = 3'd1,
      MEM_WAIT = 3'd2,
      EXEC     = 3'd3,
      HALT     = 3'd4
   } state_e;

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_IMM = 2'b10;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] rf_addr;
      logic [7:0] imm;
   } instr_t;

   function automatic logic is_legal(input logic [3:0] op);
      return op <= OP_HALT;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// pc_reg: program counter with jump load and silent wrap-around increment.
// Rev 1.0
module pc_reg #(
   parameter int PC_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inc,
   input  logic                load,
   input  logic [PC_WIDTH-1:0] load_val,
   output logic [PC_WIDTH-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + PC_WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ctrl_fsm: fetch/decode/execute controller driving the mem/rf/imm mux select.
// Rev 1.0
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int MUX_SELECT_BITS = 2,
   parameter int RF_ADDR_WIDTH   = 4,
   parameter int PC_WIDTH        = 8,
   parameter int MEM_TIMEOUT     = 15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       instr_valid,
   input  logic [15:0]                instr_data,
   output logic                       instr_ready,
   output logic [PC_WIDTH-1:0]        pc,
   output logic                       mem_rd_req,
   input  logic                       mem_rd_ack,
   output logic [DATA_WIDTH-1:0]      mem_addr,
   output logic [RF_ADDR_WIDTH-1:0]   rf_addr,
   output logic                       rf_wr_en,
   output logic                       acc_wr_en,
   output logic [MUX_SELECT_BITS-1:0] mux_select,
   output logic [DATA_WIDTH-1:0]      imm_out,
   output logic                       mem_err,
   output logic                       illegal_op,
   output logic                       halted
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_e           state;
   state_e           next_state;
   instr_t           instr;
   logic [CNT_W-1:0] wait_cnt;
   logic             ready_q;
   logic             timeout;
   logic             is_load;
   logic             pc_inc;
   logic             pc_load;

   // An ack arriving in the final wait cycle takes priority over the timeout.
   assign timeout = (state == MEM_WAIT) && !mem_rd_ack &&
                    (wait_cnt == CNT_W'(MEM_TIMEOUT));
   assign is_load = (instr.opcode == OP_LDR) || (instr.opcode == OP_LDM) ||
                    (instr.opcode == OP_LDI);

   always_comb begin
      next_state = state;
      case (state)
         FETCH:    if (instr_valid && ready_q) next_state = DECODE;
         DECODE: begin
            if (instr.opcode == OP_LDM)       next_state = MEM_WAIT;
            else if (instr.opcode == OP_HALT) next_state = HALT;
            else                              next_state = EXEC;
         end
         MEM_WAIT: begin
            if (mem_rd_ack)   next_state = EXEC;
            else if (timeout) next_state = FETCH;
         end
         EXEC:     next_state = FETCH;
         HALT:     next_state = HALT;
         default:  next_state = FETCH;
      endcase
   end

   // Ready is registered so that it reads 0 while reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         ready_q  <= 1'b0;
         instr    <= '0;
         wait_cnt <= '0;
      end else begin
         state   <= next_state;
         ready_q <= (next_state == FETCH);
         if (state == FETCH && instr_valid && ready_q) begin
            instr <= instr_t'(instr_data);
         end
         if (state == DECODE) begin
            wait_cnt <= CNT_W'(1);
         end else if (state == MEM_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_addr    <= '0;
         imm_out    <= '0;
         mem_addr   <= '0;
         mux_select <= '0;
      end else if (state == DECODE) begin
         rf_addr  <= RF_ADDR_WIDTH'(instr.rf_addr);
         imm_out  <= DATA_WIDTH'(instr.imm);
         mem_addr <= DATA_WIDTH'(instr.imm);
         case (instr.opcode)
            OP_LDM:  mux_select <= MUX_SELECT_BITS'(SEL_MEM);
            OP_LDI:  mux_select <= MUX_SELECT_BITS'(SEL_IMM);
            default: mux_select <= MUX_SELECT_BITS'(SEL_RF);
         endcase
      end
   end

   assign instr_ready = ready_q;
   assign mem_rd_req  = (state == MEM_WAIT);
   assign acc_wr_en   = (state == EXEC) && is_load;
   assign rf_wr_en    = (state == EXEC) && (instr.opcode == OP_STR);
   assign illegal_op  = (state == EXEC) && !is_legal(instr.opcode);
   assign mem_err     = timeout;
   assign halted      = (state == HALT);

   assign pc_load = (state == EXEC) && (instr.opcode == OP_JMP);
   assign pc_inc  = ((state == EXEC) && (instr.opcode != OP_JMP)) || timeout;

   pc_reg #(
      .PC_WIDTH (PC_WIDTH)
   ) u_pc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (PC_WIDTH'(instr.imm)),
      .pc       (pc)
   );

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// tb_ctrl_fsm: directed and random instruction streams scored against a behavioural model.
// Rev 1.0
module tb_ctrl_fsm;

   localparam int TMO = 15;
   localparam int EV_ACCEPT = 0, EV_ACC = 1, EV_RF = 2, EV_MERR = 3, EV_ILL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr_data = 16'h0;
   logic        mem_rd_ack = 1'b0;
   logic        instr_ready;
   logic [7:0]  pc;
   logic        mem_rd_req;
   logic [7:0]  mem_addr;
   logic [3:0]  rf_addr;
   logic        rf_wr_en;
   logic        acc_wr_en;
   logic [1:0]  mux_select;
   logic [7:0]  imm_out;
   logic        mem_err;
   logic        illegal_op;
   logic        halted;

   ctrl_fsm dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .instr_ready (instr_ready),
      .pc          (pc),
      .mem_rd_req  (mem_rd_req),
      .mem_rd_ack  (mem_rd_ack),
      .mem_addr    (mem_addr),
      .rf_addr     (rf_addr),
      .rf_wr_en    (rf_wr_en),
      .acc_wr_en   (acc_wr_en),
      .mux_select  (mux_select),
      .imm_out     (imm_out),
      .mem_err     (mem_err),
      .illegal_op  (illegal_op),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind; int pc; int sel; int imm; int mem; int rfa; int req; int gap;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;
   int  m_pc     = 0;
   int  next_gap = -1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic compare_ev(input ev_t a);
      ev_t e;
      bit  ok;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_event: got kind=%0d pc=%0h, expected nothing", a.kind, a.pc);
         return;
      end
      e  = exp_q.pop_front();
      ok = (a.kind == e.kind) && (a.pc == e.pc);
      if (e.kind == EV_ACCEPT) ok = ok && (e.gap < 0 || a.gap == e.gap);
      else ok = ok && a.sel == e.sel && a.imm == e.imm && a.mem == e.mem &&
                a.rfa == e.rfa && a.req == e.req;
      if (ok) n_pass++;
      else $display("FAIL event: got kind=%0d pc=%0h sel=%0d imm=%0h mem=%0h rf=%0d req=%0d gap=%0d, expected kind=%0d pc=%0h sel=%0d imm=%0h mem=%0h rf=%0d req=%0d gap=%0d",
                    a.kind, a.pc, a.sel, a.imm, a.mem, a.rfa, a.req, a.gap,
                    e.kind, e.pc, e.sel, e.imm, e.mem, e.rfa, e.req, e.gap);
   endtask

   // Monitor: an accept shows as instr_ready falling; every strobe pops one expectation.
   int   cyc = 0;
   int   last_acc = -1;
   int   req_cnt = 0;
   logic prev_ready = 1'b0;

   always @(negedge clk) begin : mon
      ev_t a;
      int  nstb;
      #2;
      if (!rst_n) begin
         prev_ready = 1'b0;
         req_cnt    = 0;
         last_acc   = -1;
      end else begin
         cyc++;
         if (mem_rd_req) req_cnt++;
         if (prev_ready && !instr_ready) begin
            a = '{EV_ACCEPT, int'(pc), 0, 0, 0, 0, 0, (last_acc < 0) ? -1 : cyc - last_acc};
            compare_ev(a);
            last_acc = cyc;
            req_cnt  = 0;
         end
         nstb = int'(acc_wr_en) + int'(rf_wr_en) + int'(mem_err) + int'(illegal_op);
         if (nstb > 1) begin
            n_checks++;
            $display("FAIL strobe_overlap: got %0d strobes, expected at most 1", nstb);
         end
         a = '{0, int'(pc), int'(mux_select), int'(imm_out), int'(mem_addr),
               int'(rf_addr), req_cnt, 0};
         if (acc_wr_en)  begin a.kind = EV_ACC;  compare_ev(a); end
         if (rf_wr_en)   begin a.kind = EV_RF;   compare_ev(a); end
         if (mem_err)    begin a.kind = EV_MERR; compare_ev(a); end
         if (illegal_op) begin a.kind = EV_ILL;  compare_ev(a); end
         prev_ready = instr_ready;
      end
   end

   // k for LDM: 1..15 = ack in that wait cycle, 0 = never ack, -1 = reset in wait cycle 3.
   task automatic issue(input int op, input int ra, input int imm, input int k);
      int kind;
      int sel;
      int n;
      sel = (op == 2) ? 1 : (op == 3) ? 2 : 0;
      exp_q.push_back('{EV_ACCEPT, m_pc, 0, 0, 0, 0, 0, next_gap});
      case (op)
         1, 3:       kind = EV_ACC;
         2:          kind = (k > 0) ? EV_ACC : (k == 0) ? EV_MERR : -1;
         4:          kind = EV_RF;
         0, 5, 6:    kind = -1;
         default:    kind = EV_ILL;
      endcase
      if (kind >= 0)
         exp_q.push_back('{kind, m_pc, sel, imm, imm, ra,
                           (op == 2) ? ((k > 0) ? k : TMO) : 0, 0});
      if (op == 2 && k < 0)      begin m_pc = 0; next_gap = -1; end
      else if (op == 5)          begin m_pc = imm; next_gap = 3; end
      else if (op != 6)          begin m_pc = (m_pc + 1) % 256;
                                       next_gap = (op != 2) ? 3 : (k > 0) ? 3 + k : 2 + TMO; end

      instr_data  = {4'(op), 4'(ra), 8'(imm)};
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 40) begin @(negedge clk); n++; end
      if (!instr_ready) begin
         n_checks++;
         $display("FAIL ready_timeout: got instr_ready=0 for %0d cycles, expected 1", n);
         return;
      end
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'($urandom_range(0, 1));
      instr_data  = 16'($urandom);
      if (op == 2) begin
         n = 0;
         while (!mem_rd_req && n < 5) begin @(negedge clk); n++; end
         for (int c = 1; c <= TMO; c++) begin
            if (c > 1) @(negedge clk);
            if (k < 0 && c == 3) begin
               rst_n       = 1'b0;
               instr_valid = 1'b0;
               #1;
               chk("rst_mid_mem_rd_req", int'(mem_rd_req), 0);
               chk("rst_mid_pc", int'(pc), 0);
               chk("rst_mid_strobes", int'({acc_wr_en, rf_wr_en, mem_err, illegal_op}), 0);
               @(negedge clk);
               rst_n      = 1'b1;
               mem_rd_ack = 1'b1;
               repeat (2) @(negedge clk);
               mem_rd_ack = 1'b0;
               break;
            end
            mem_rd_ack = (c == k);
            if (c == k) begin
               @(negedge clk);
               mem_rd_ack = 1'b0;
               break;
            end
         end
      end
   endtask

   task automatic issue_random();
      int r;
      int op;
      int k;
      r  = $urandom_range(0, 7);
      op = (r <= 5) ? r : $urandom_range(7, 15);
      k  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15);
      issue(op, $urandom_range(0, 15), $urandom_range(0, 255), k);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("reset_pc", int'(pc), 0);
      chk("reset_instr_ready", int'(instr_ready), 0);
      chk("reset_mem_rd_req", int'(mem_rd_req), 0);
      chk("reset_strobes", int'({acc_wr_en, rf_wr_en, mem_err, illegal_op}), 0);
      chk("reset_halted", int'(halted), 0);
      chk("reset_mux_select", int'(mux_select), 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(3, 0, 8'h3A, 0);     // LDI 0x3A
      issue(2, 0, 8'h20, 4);     // LDM, ack in 4th wait cycle
      issue(2, 1, 8'h44, 0);     // LDM, timeout
      issue(5, 0, 8'hFF, 0);     // JMP 0xFF
      issue(0, 0, 8'h00, 0);     // NOP at 0xFF, pc wraps
      issue(4, 5, 8'h11, 0);     // STR r5
      issue(4'hA, 2, 8'h33, 0);  // illegal opcode
      issue(1, 7, 8'h09, 0);     // LDR r7
      issue(2, 3, 8'h55, TMO);   // ack in the timeout cycle wins

      for (int i = 0; i < 150; i++) issue_random();

      issue(2, 6, 8'h77, -1);    // reset during MEM_WAIT
      for (int i = 0; i < 10; i++) issue_random();

      issue(6, 0, 8'h00, 0);     // HALT
      repeat (2) @(negedge clk);
      #1;
      chk("halted", int'(halted), 1);
      instr_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk("halt_instr_ready", int'(instr_ready), 0);
      end
      chk("halt_pc", int'(pc), m_pc);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
